// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: 4-player buzzer arbitration with
// round-robin grant, per-player lockout, answer countdown and scores.
module quiz_round_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int ANSWER_SEC = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic        host_start,
  input  logic        host_clear,
  input  logic        judge_ok,
  input  logic        judge_ng,
  output logic [1:0]  state,
  output logic [3:0]  winner,
  output logic [3:0]  lockout,
  output logic [3:0]  time_left,
  output logic [15:0] scores,
  output logic        timeout,
  output logic        round_void
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [3:0] SEC_LOAD = 4'(ANSWER_SEC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      winner_q, winner_d;
  logic [3:0]      lock_q, lock_d;
  logic [3:0]      tl_q, tl_d;
  logic [3:0][3:0] score_q, score_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [DW-1:0]   div_q, div_d;
  logic            to_q, to_d;
  logic            void_q, void_d;

  logic [3:0] elig;
  logic       gnt_found;
  logic [1:0] gnt_idx;
  logic [1:0] idx;
  logic       tick;

  assign elig = btn & ~lock_q;
  assign tick = (div_q == DIV_MAX);

  // Round-robin search starting at ptr_q
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    lock_d   = lock_q;
    tl_d     = tl_q;
    score_d  = score_q;
    ptr_d    = ptr_q;
    div_d    = div_q;
    to_d     = 1'b0;
    void_d   = 1'b0;
    if (host_clear) begin
      state_d  = S_IDLE;
      winner_d = 4'b0;
      lock_d   = 4'b0;
      div_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          lock_d = lock_q | btn;
          if (host_start) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (&lock_q) begin
            state_d = S_IDLE;
            lock_d  = 4'b0;
            void_d  = 1'b1;
          end else if (gnt_found) begin
            state_d  = S_ANSWER;
            winner_d = 4'b0001 << gnt_idx;
            ptr_d    = gnt_idx + 2'd1;
            tl_d     = SEC_LOAD;
            div_d    = '0;
          end
        end
        S_ANSWER: begin
          if (judge_ok) begin
            for (int i = 0; i < 4; i++)
              if (winner_q[i] && score_q[i] != 4'd9)
                score_d[i] = score_q[i] + 4'd1;
            state_d  = S_IDLE;
            winner_d = 4'b0;
            lock_d   = 4'b0;
          end else if (judge_ng) begin
            state_d  = S_ARMED;
            lock_d   = lock_q | winner_q;
            winner_d = 4'b0;
          end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
              if (tl_q == 4'd1) begin
                tl_d     = 4'd0;
                to_d     = 1'b1;
                lock_d   = lock_q | winner_q;
                winner_d = 4'b0;
                state_d  = S_ARMED;
              end else begin
                tl_d = tl_q - 4'd1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      winner_q <= 4'b0;
      lock_q   <= 4'b0;
      tl_q     <= 4'b0;
      score_q  <= '0;
      ptr_q    <= 2'b0;
      div_q    <= '0;
      to_q     <= 1'b0;
      void_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      lock_q   <= lock_d;
      tl_q     <= tl_d;
      score_q  <= score_d;
      ptr_q    <= ptr_d;
      div_q    <= div_d;
      to_q     <= to_d;
      void_q   <= void_d;
    end
  end

  assign state      = state_q;
  assign winner     = winner_q;
  assign lockout    = lock_q;
  assign time_left  = tl_q;
  assign scores     = score_q;
  assign timeout    = to_q;
  assign round_void = void_q;

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per answer-countdown second.
REQ-002 SHALL have parameter ANSWER_SEC, default 9, countdown start value (range 1..9).
REQ-003 clk  input  1  single clock; all registers on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  one-cycle press pulses per player (already debounced and edge-detected upstream).
REQ-006 host_start  input  1  one-cycle pulse, opens a round.
REQ-007 host_clear  input  1  one-cycle pulse, aborts the round to IDLE.
REQ-008 judge_ok / judge_ng  input  1 each  one-cycle pulses, correct / wrong answer verdict.
REQ-009 state  output  2  0=IDLE, 1=ARMED, 2=ANSWER (3 unused).
REQ-010 winner  output  4  one-hot current answering player, 0 when none.
REQ-011 lockout  output  4  per-player lockout flags.
REQ-012 time_left  output  4  remaining answer seconds, binary 0..9.
REQ-013 scores  output  16  player i score at [4i+3:4i], binary 0..9.
REQ-014 timeout / round_void  output  1 each  one-cycle event pulses.

Function
REQ-015 All outputs SHALL be registered; every response SHALL appear on the clock edge after the causing input.
REQ-016 IDLE: btn[i] SHALL set lockout[i] (false start); host_start SHALL move to ARMED.
REQ-017 ARMED: eligible = btn & ~lockout; if nonzero, SHALL grant exactly one player, set winner one-hot, load time_left=ANSWER_SEC, clear tick divider, enter ANSWER.
REQ-018 Grant SHALL be round-robin: search starts at index ptr (2-bit, reset 0) upward modulo 4; after a grant ptr = granted index + 1 mod 4.
REQ-019 ARMED with lockout==4'b1111 SHALL return to IDLE, clear lockout, pulse round_void for one cycle.
REQ-020 ANSWER: btn SHALL be ignored; divider SHALL count 0..TICK_DIV-1 and produce a tick at TICK_DIV-1, first tick TICK_DIV cycles after ANSWER entry.
REQ-021 On tick time_left SHALL decrement; tick with time_left==1 SHALL set time_left=0, pulse timeout, set lockout of winner, clear winner, enter ARMED.
REQ-022 judge_ok in ANSWER SHALL increment winner's score (saturate at 9), clear winner and lockout, enter IDLE.
REQ-023 judge_ng in ANSWER SHALL set winner's lockout bit, clear winner, enter ARMED (re-open to remaining players).
REQ-024 time_left SHALL hold its value outside ANSWER.
REQ-025 Priority on the same cycle: host_clear > judge_ok > judge_ng > tick timeout.
REQ-026 host_clear in any state SHALL enter IDLE, clear winner and lockout, not change scores or ptr.
REQ-027 host_start outside IDLE and judge_* outside ANSWER SHALL be ignored.
REQ-028 Scores SHALL change only by REQ-022 or reset.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, winner=0, lockout=0, time_left=0, scores=0, ptr=0, divider=0, timeout=0, round_void=0.
REQ-030 Reset deasserted mid-ANSWER SHALL resume from IDLE with no residual pulse.

Verification (TICK_DIV=4, ANSWER_SEC=3)
REQ-031 host_start, then btn=0100 -> next edge state=2, winner=0100, time_left=3; judge_ok -> scores[11:8]=1, state=0.
REQ-032 ptr=0, btn=1111 in ARMED -> winner=0001, ptr=1; judge_ng, btn=1111 -> winner=0010.
REQ-033 ARMED grant, no judge -> time_left 3,2,1,0 at 4-cycle spacing; timeout pulses with 1->0, lockout bit set, state=1.
REQ-034 btn=1000 in IDLE, host_start, btn=1000 -> no grant, lockout=1000; three judge_ng rounds on remaining players -> round_void pulse, state=0, lockout=0.
REQ-035 judge_ok and judge_ng same cycle -> scored as ok; host_clear with judge_ok -> state=0, score unchanged.
REQ-036 Score at 9 plus judge_ok -> stays 9; rst_n low mid-ANSWER -> all outputs zero immediately.
